// File: rtl/imgproc_block_sched.sv
`default_nettype none
// ============================================================================
// Module   : imgproc_block_sched
// Purpose  : Streams a frame word-by-word from frame/background RAMs, marks
//            foreground pixels and counts them. Optional background update
//            via macro IMGPROC_BG_UPDATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imgproc_block_sched #(
  parameter int PIXELS_PER_BLOCK = 16,
  parameter int NUMBER_OF_BLOCKS = 4800,
  parameter int ADDR_W           = 13,
  parameter int PIX_W            = 8,
  parameter int CNT_W            = 24,
  parameter int ALPHA_SHIFT      = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [PIX_W-1:0]                  threshold,
  input  logic [PIXELS_PER_BLOCK*PIX_W-1:0] read_pixel,
  input  logic [PIXELS_PER_BLOCK*PIX_W-1:0] bg_pixel,
  output logic [ADDR_W-1:0]                 read_address,
  output logic [ADDR_W-1:0]                 write_address,
  output logic [PIXELS_PER_BLOCK*PIX_W-1:0] write_pixel,
  output logic                              write_en,
  output logic                              busy,
  output logic                              done,
  output logic [CNT_W-1:0]                  fg_count
`ifdef IMGPROC_BG_UPDATE_EN
  ,
  output logic                              bg_write_en,
  output logic [PIXELS_PER_BLOCK*PIX_W-1:0] bg_write_pixel
`endif
);

  localparam int                c_PC_W      = $clog2(PIXELS_PER_BLOCK + 1);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUMBER_OF_BLOCKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                              r_state;
  logic [PIX_W-1:0]                    r_thr;
  logic [ADDR_W-1:0]                   r_rd_addr;
  logic                                r_v1;
  logic [ADDR_W-1:0]                   r_a1;
  logic                                r_we;
  logic [ADDR_W-1:0]                   r_wa;
  logic [PIXELS_PER_BLOCK*PIX_W-1:0]   r_wp;
  logic                                r_busy;
  logic                                r_done;
  logic [CNT_W-1:0]                    r_fg;

  logic [PIXELS_PER_BLOCK-1:0]         w_fg;
  logic [PIXELS_PER_BLOCK*PIX_W-1:0]   w_class;
  logic [c_PC_W-1:0]                   w_pop;
  logic [CNT_W:0]                      w_sum;

`ifdef IMGPROC_BG_UPDATE_EN
  logic                                r_bgwe;
  logic [PIXELS_PER_BLOCK*PIX_W-1:0]   r_bgwp;
  logic [PIXELS_PER_BLOCK*PIX_W-1:0]   w_bg_new;
`else
  logic                                w_unused_alpha;
  assign w_unused_alpha = (ALPHA_SHIFT != 0);
`endif

  // Per-lane classification on the word returned for address r_a1.
  for (genvar gi = 0; gi < PIXELS_PER_BLOCK; gi++) begin : g_lane
    logic [PIX_W-1:0] w_px;
    logic [PIX_W-1:0] w_bg;
    logic [PIX_W:0]   w_diff;

    assign w_px   = read_pixel[gi*PIX_W +: PIX_W];
    assign w_bg   = bg_pixel[gi*PIX_W +: PIX_W];
    assign w_diff = (w_px >= w_bg) ? ({1'b0, w_px} - {1'b0, w_bg})
                                   : ({1'b0, w_bg} - {1'b0, w_px});
    assign w_fg[gi] = (w_diff > {1'b0, r_thr});
    assign w_class[gi*PIX_W +: PIX_W] = {PIX_W{w_fg[gi]}};

`ifdef IMGPROC_BG_UPDATE_EN
    logic signed [PIX_W+1:0] w_delta;
    logic signed [PIX_W+1:0] w_step;
    logic signed [PIX_W+1:0] w_upd;

    assign w_delta = $signed({2'b00, w_px}) - $signed({2'b00, w_bg});
    assign w_step  = w_delta >>> ALPHA_SHIFT;
    assign w_upd   = $signed({2'b00, w_bg}) + w_step;
    // Sign bit flags underflow; bit PIX_W flags overflow of a positive sum.
    assign w_bg_new[gi*PIX_W +: PIX_W] = w_fg[gi]       ? w_bg :
                                         w_upd[PIX_W+1] ? {PIX_W{1'b0}} :
                                         w_upd[PIX_W]   ? {PIX_W{1'b1}} :
                                                          w_upd[PIX_W-1:0];
`endif
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < PIXELS_PER_BLOCK; i++) begin
      w_pop = w_pop + c_PC_W'(w_fg[i]);
    end
  end

  assign w_sum = {1'b0, r_fg} + (CNT_W+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_thr     <= '0;
      r_rd_addr <= '0;
      r_v1      <= 1'b0;
      r_a1      <= '0;
      r_we      <= 1'b0;
      r_wa      <= '0;
      r_wp      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fg      <= '0;
`ifdef IMGPROC_BG_UPDATE_EN
      r_bgwe    <= 1'b0;
      r_bgwp    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_v1   <= (r_state == S_RUN);
      r_a1   <= r_rd_addr;
      r_we   <= r_v1;
`ifdef IMGPROC_BG_UPDATE_EN
      r_bgwe <= r_v1;
`endif
      if (r_v1) begin
        r_wa <= r_a1;
        r_wp <= w_class;
        r_fg <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
`ifdef IMGPROC_BG_UPDATE_EN
        r_bgwp <= w_bg_new;
`endif
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_rd_addr <= '0;
            r_fg      <= '0;
            r_busy    <= 1'b1;
            r_thr     <= threshold;
          end
        end
        S_RUN: begin
          if (r_rd_addr == c_LAST_ADDR) begin
            r_state <= S_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          // Last word is on the write port this cycle; finish next cycle.
          if (r_we && (r_wa == c_LAST_ADDR)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_address  = r_rd_addr;
  assign write_address = r_wa;
  assign write_pixel   = r_wp;
  assign write_en      = r_we;
  assign busy          = r_busy;
  assign done          = r_done;
  assign fg_count      = r_fg;
`ifdef IMGPROC_BG_UPDATE_EN
  assign bg_write_en    = r_bgwe;
  assign bg_write_pixel = r_bgwp;
`endif

endmodule
`default_nettype wire

// File: doc/imgproc_block_sched.md
IMGPROC_BLOCK_SCHED -- requirements
Module: imgproc_block_sched

Interface
REQ-001 SHALL have parameter PIXELS_PER_BLOCK, default 16: pixels per memory word.
REQ-002 SHALL have parameter NUMBER_OF_BLOCKS, default 4800: words per frame.
REQ-003 SHALL have parameter ADDR_W, default 13: address width; NUMBER_OF_BLOCKS <= 2^ADDR_W.
REQ-004 SHALL have parameter PIX_W, default 8: bits per pixel.
REQ-005 SHALL have parameter CNT_W, default 24: foreground-count width.
REQ-006 SHALL have parameter ALPHA_SHIFT, default 3: background-update rate shift (used only under REQ-031).
REQ-007 SHALL have port clk  in  1  the single clock; all logic samples on its rising edge.
REQ-008 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-009 SHALL have port start  in  1  one-cycle frame-start request.
REQ-010 SHALL have port threshold  in  PIX_W  classification threshold; sampled on accepted start.
REQ-011 SHALL have port read_pixel  in  PIXELS_PER_BLOCK*PIX_W  frame word; valid one cycle after read_address.
REQ-012 SHALL have port bg_pixel  in  PIXELS_PER_BLOCK*PIX_W  background word; same timing as read_pixel.
REQ-013 SHALL have port read_address  out  ADDR_W  address presented to both frame and background RAMs.
REQ-014 SHALL have port write_address  out  ADDR_W  result word address.
REQ-015 SHALL have port write_pixel  out  PIXELS_PER_BLOCK*PIX_W  classified word.
REQ-016 SHALL have port write_en  out  1  result write strobe.
REQ-017 SHALL have port busy  out  1  high from accepted start until done.
REQ-018 SHALL have port done  out  1  one-cycle end-of-frame pulse.
REQ-019 SHALL have port fg_count  out  CNT_W  foreground pixels in the current/last frame.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DRAIN; start in IDLE moves to RUN; start outside IDLE is ignored.
REQ-021 SHALL, on accepted start: read_address<=0, fg_count<=0, busy<=1, latch threshold.
REQ-022 SHALL in RUN increment read_address by 1 per cycle; after issuing NUMBER_OF_BLOCKS-1 enter DRAIN and hold read_address at that value.
REQ-023 SHALL classify each pixel lane i: output all-ones if |read_pixel[i]-bg_pixel[i]| > latched threshold (unsigned, PIX_W+1-bit difference), else zero; equality is background.
REQ-024 SHALL register results so write_en/write_address/write_pixel for address A appear exactly 2 cycles after read_address=A; write_address equals A.
REQ-025 SHALL assert write_en for exactly NUMBER_OF_BLOCKS cycles per frame, consecutively, one per address 0..NUMBER_OF_BLOCKS-1, no gaps or repeats.
REQ-026 SHALL add the per-word foreground popcount to fg_count in the same cycle write_en is asserted; fg_count saturates at 2^CNT_W-1 and holds its final value until the next accepted start.
REQ-027 SHALL leave DRAIN when the last write occurs, pulse done for one cycle the following cycle, deassert busy with done, return to IDLE; start on the done cycle is accepted.
REQ-028 SHALL keep write_en low in IDLE; write_pixel/write_address hold last values.

Reset
REQ-029 SHALL, when rst_n=0 at a clock edge (including mid-frame), enter IDLE, discard in-flight words, and set read_address, write_address, write_pixel, fg_count to 0 and write_en, busy, done to 0.
REQ-030 SHALL produce no write_en in the cycle after rst_n returns high.

Configuration
REQ-031 SHALL, when macro IMGPROC_BG_UPDATE_EN is defined, add outputs bg_write_en (1) and bg_write_pixel (PIXELS_PER_BLOCK*PIX_W), aligned with write_en at write_address; per lane background pixels become bg+((px-bg)>>>ALPHA_SHIFT) (signed, result clamped to 0..2^PIX_W-1), foreground lanes keep bg unchanged.
REQ-032 SHALL, when IMGPROC_BG_UPDATE_EN is undefined, omit those ports and all update logic; other behaviour identical.

Verification
REQ-033 SHALL cover: reset, start with threshold=10, px=bg=0x40 all words -> 4800 writes, all write_pixel=0, fg_count=0, done 4802 cycles after start.
REQ-034 SHALL cover: one lane px=0x4B, bg=0x40 (diff 11) per word, threshold=10 -> that lane 0xFF every word, fg_count=4800; diff 10 -> 0x00, fg_count=0.
REQ-035 SHALL cover: px=0x00, bg=0xFF all lanes, threshold=0 -> fg_count=76800 (CNT_W=24); with CNT_W=16 -> fg_count=65535.
REQ-036 SHALL cover: start pulsed at read_address=100 mid-frame -> ignored, write sequence unchanged; start on done cycle -> next frame begins, read_address=0 next cycle.
REQ-037 SHALL cover: rst_n low at read_address=2000 for one cycle -> all outputs 0 next cycle, no write_en until new start.
REQ-038 SHALL cover (IMGPROC_BG_UPDATE_EN, ALPHA_SHIFT=3): px=0x48, bg=0x40, threshold=10 -> bg_write_pixel lane=0x41; px=0x80 -> lane unchanged 0x40.
